// File: rtl/d_sram_bridge_if.sv
// -----------------------------------------------------------------------------
// d_sram_bridge_if
//   SRAM-like data bus between the data-side bridge and the memory system.
//   Request channel: data_req/data_wr/data_size/data_addr/data_wdata.
//   Response channel: data_addr_ok (request taken), data_data_ok (read data
//   valid or write complete), data_rdata.
//   master : the bridge (drives the request channel)
//   slave  : the memory side (drives the handshake/response)
// -----------------------------------------------------------------------------
interface d_sram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/d_sram_bridge.sv
// -----------------------------------------------------------------------------
// d_sram_bridge
//   Data-side memory responder for the 5-stage MIPS core. Takes the M-stage
//   load/store, runs it on the SRAM-like bus, stalls the pipeline via d_stall_o
//   until the bus completes, and holds the result in DONE until the whole
//   pipeline advances (longest_stall_i low).
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   mem_en_i/mem_wr_i     M-stage access valid / store(1) or load(0)
//   mem_size_i            0 byte, 1 half, 2 word
//   mem_addr_i/mem_wdata_i byte address / lane-shifted store data
//   flush_exceptionM_i    exception flush of the M stage
//   longest_stall_i       global pipeline stall (includes d_stall_o)
//   mem_rdata_o           registered load data
//   d_stall_o             data-side stall request
//   mem_adel_o/mem_ades_o misaligned load/store (alignment check build only)
//   bus                   SRAM-like bus, master side
//
// Build option
//   DSB_ALIGN_CHECK_EN    when defined, misaligned accesses are rejected in
//                         IDLE and flagged on mem_adel_o/mem_ades_o; when
//                         undefined every access goes to the bus unchanged.
// -----------------------------------------------------------------------------
module d_sram_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en_i,
   input  logic              mem_wr_i,
   input  logic [1:0]        mem_size_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              flush_exceptionM_i,
   input  logic              longest_stall_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              d_stall_o,
   output logic              mem_adel_o,
   output logic              mem_ades_o,
   d_sram_bridge_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              discard_q, discard_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              req_wr_q, req_wr_d;
   logic [1:0]        req_size_q, req_size_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

   logic misaligned;
   logic accept;
   logic discard_eff;
   logic d_stall;

   // ---------------------------------------------------------------------------
   // Alignment check
   // ---------------------------------------------------------------------------
`ifdef DSB_ALIGN_CHECK_EN
   assign misaligned = ((mem_size_i == 2'd1) &  mem_addr_i[0]) |
                       ((mem_size_i == 2'd2) & (mem_addr_i[1:0] != 2'b00));
   assign mem_adel_o = mem_en_i & ~mem_wr_i & misaligned;
   assign mem_ades_o = mem_en_i &  mem_wr_i & misaligned;
`else
   assign misaligned = 1'b0;
   assign mem_adel_o = 1'b0;
   assign mem_ades_o = 1'b0;
`endif

   assign accept = mem_en_i & ~flush_exceptionM_i & ~misaligned;

   // A flush arriving in the same cycle the bus completes must also suppress
   // the result, so the registered flag is OR-ed with the live flush.
   assign discard_eff = discard_q | flush_exceptionM_i;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         discard_q   <= 1'b0;
         rdata_q     <= '0;
         req_wr_q    <= 1'b0;
         req_size_q  <= 2'd0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         rdata_q     <= rdata_d;
         req_wr_q    <= req_wr_d;
         req_size_q  <= req_size_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state / outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      rdata_d     = rdata_q;
      req_wr_d    = req_wr_q;
      req_size_d  = req_size_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      d_stall     = 1'b0;

      case (state_q)
         IDLE: begin
            d_stall = accept;
            if (accept) begin
               req_wr_d    = mem_wr_i;
               req_size_d  = mem_size_i;
               req_addr_d  = mem_addr_i;
               req_wdata_d = mem_wdata_i;
               state_d     = ADDR;
            end
         end

         ADDR: begin
            // Request stays up until the slave takes it; a flush only marks
            // the transaction for discard.
            d_stall = 1'b1;
            if (flush_exceptionM_i) discard_d = 1'b1;
            if (bus.data_addr_ok) begin
               if (bus.data_data_ok) begin
                  if (!discard_eff && !req_wr_q) rdata_d = bus.data_rdata;
                  state_d = discard_eff ? IDLE : DONE;
               end else begin
                  state_d = DATA;
               end
            end
         end

         DATA: begin
            d_stall = 1'b1;
            if (flush_exceptionM_i) discard_d = 1'b1;
            if (bus.data_data_ok) begin
               if (!discard_eff && !req_wr_q) rdata_d = bus.data_rdata;
               state_d = discard_eff ? IDLE : DONE;
            end
         end

         DONE: begin
            // Hold the result until the pipeline actually moves.
            if (flush_exceptionM_i || !longest_stall_i) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      if (state_d == IDLE) discard_d = 1'b0;
   end

   // ---------------------------------------------------------------------------
   // Bus and CPU outputs (bus fields always from the request registers)
   // ---------------------------------------------------------------------------
   assign bus.data_req   = (state_q == ADDR);
   assign bus.data_wr    = req_wr_q;
   assign bus.data_size  = req_size_q;
   assign bus.data_addr  = req_addr_q;
   assign bus.data_wdata = req_wdata_q;

   assign mem_rdata_o = rdata_q;
   assign d_stall_o   = d_stall;

endmodule

// File: tb/tb_d_sram_bridge.sv
module tb_d_sram_bridge;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_en, mem_wr, flush, ext_stall;
   logic [1:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          d_stall, adel, ades, longest_stall;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   d_sram_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   assign longest_stall = d_stall | ext_stall;

   d_sram_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_en_i          (mem_en),
      .mem_wr_i          (mem_wr),
      .mem_size_i        (mem_size),
      .mem_addr_i        (mem_addr),
      .mem_wdata_i       (mem_wdata),
      .flush_exceptionM_i(flush),
      .longest_stall_i   (longest_stall),
      .mem_rdata_o       (mem_rdata),
      .d_stall_o         (d_stall),
      .mem_adel_o        (adel),
      .mem_ades_o        (ades),
      .bus               (bus_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_sb(input string tag);
      logic [DW-1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, mem_rdata);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 64'(mem_rdata), 64'(e));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic wr, input logic [1:0] sz, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
      mem_en = 1'b1; mem_wr = wr; mem_size = sz; mem_addr = a; mem_wdata = wd;
   endtask

   initial begin
      rst = 1'b1; mem_en = 0; mem_wr = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
      flush = 0; ext_stall = 0;
      bus_if.data_addr_ok = 0; bus_if.data_data_ok = 0; bus_if.data_rdata = 0;
      step(); step();
      rst = 1'b0;

      // ---- reset state
      @(negedge clk);
      chk("rst_dstall", 64'(d_stall), 0);
      chk("rst_req",    64'(bus_if.data_req), 0);
      chk("rst_rdata",  64'(mem_rdata), 0);
      chk("rst_addr",   64'(bus_if.data_addr), 0);
      chk("rst_adel",   64'({adel, ades}), 0);
      step();

      // ---- load word 0x1000, addr_ok on 2nd ADDR cycle, data_ok one later
      req(0, 2'd2, 32'h1000, 0);
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      chk("lw_c1_stall", 64'(d_stall), 1);
      chk("lw_c1_req",   64'(bus_if.data_req), 0);
      step();
      @(negedge clk);
      chk("lw_c2_req",   64'(bus_if.data_req), 1);
      chk("lw_c2_stall", 64'(d_stall), 1);
      step();
      bus_if.data_addr_ok = 1;
      @(negedge clk);
      chk("lw_c3_req",   64'(bus_if.data_req), 1);
      chk("lw_c3_addr",  64'(bus_if.data_addr), 64'h1000);
      chk("lw_c3_size",  64'(bus_if.data_size), 2);
      chk("lw_c3_wr",    64'(bus_if.data_wr), 0);
      step();
      bus_if.data_addr_ok = 0;
      bus_if.data_data_ok = 1; bus_if.data_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("lw_c4_req",   64'(bus_if.data_req), 0);
      chk("lw_c4_stall", 64'(d_stall), 1);
      step();
      bus_if.data_data_ok = 0; bus_if.data_rdata = 0;
      @(negedge clk);
      chk("lw_done_stall", 64'(d_stall), 0);
      chk_sb("lw_done_rdata");
      step();
      mem_en = 0;
      @(negedge clk);
      chk("lw_idle_stall", 64'(d_stall), 0);
      chk("lw_idle_req",   64'(bus_if.data_req), 0);
      step();

      // ---- store byte 0x2003, addr_ok & data_ok together
      req(1, 2'd0, 32'h2003, 32'h000000AA);
      exp_q.push_back(32'hDEADBEEF);   // stores leave mem_rdata alone
      @(negedge clk);
      chk("sb_c1_stall", 64'(d_stall), 1);
      step();
      bus_if.data_addr_ok = 1; bus_if.data_data_ok = 1; bus_if.data_rdata = 32'h55555555;
      @(negedge clk);
      chk("sb_c2_stall", 64'(d_stall), 1);
      chk("sb_c2_req",   64'(bus_if.data_req), 1);
      chk("sb_c2_wr",    64'(bus_if.data_wr), 1);
      chk("sb_c2_size",  64'(bus_if.data_size), 0);
      chk("sb_c2_addr",  64'(bus_if.data_addr), 64'h2003);
      chk("sb_c2_wdata", 64'(bus_if.data_wdata), 64'hAA);
      step();
      bus_if.data_addr_ok = 0; bus_if.data_data_ok = 0; bus_if.data_rdata = 0;
      @(negedge clk);
      chk("sb_done_stall", 64'(d_stall), 0);
      chk("sb_done_req",   64'(bus_if.data_req), 0);
      chk_sb("sb_done_rdata");
      step();
      mem_en = 0;
      step();

      // ---- load held in DONE by an external stall for 3 cycles
      req(0, 2'd2, 32'h3000, 0);
      exp_q.push_back(32'h12345678);
      step();
      bus_if.data_addr_ok = 1; bus_if.data_data_ok = 1; bus_if.data_rdata = 32'h12345678;
      @(negedge clk);
      chk("ls_addr_stall", 64'(d_stall), 1);
      step();
      bus_if.data_addr_ok = 0; bus_if.data_data_ok = 0; bus_if.data_rdata = 0;
      ext_stall = 1;
      chk_sb("ls_done_rdata");
      for (int i = 0; i < 3; i++) begin
         // mem_en still high: d_stall low proves the FSM has not re-entered IDLE
         @(negedge clk);
         chk("ls_hold_stall", 64'(d_stall), 0);
         chk("ls_hold_rdata", 64'(mem_rdata), 64'h12345678);
         chk("ls_hold_req",   64'(bus_if.data_req), 0);
         step();
         if (i == 2) ext_stall = 0;
      end
      @(negedge clk);
      chk("ls_adv_stall", 64'(d_stall), 0);
      step();
      mem_en = 0;
      @(negedge clk);
      chk("ls_idle_rdata", 64'(mem_rdata), 64'h12345678);
      step();

      // ---- flush in DATA: bus completes, data dropped, DATA -> IDLE
      req(0, 2'd2, 32'h4000, 0);
      exp_q.push_back(32'h12345678);
      step();
      bus_if.data_addr_ok = 1;
      step();
      bus_if.data_addr_ok = 0;
      flush = 1;
      @(negedge clk);
      chk("fl_data_stall", 64'(d_stall), 1);
      step();
      flush = 0;
      bus_if.data_data_ok = 1; bus_if.data_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("fl_ok_stall", 64'(d_stall), 1);
      step();
      bus_if.data_data_ok = 0; bus_if.data_rdata = 0;
      // new access right away: stall only rises if the FSM is back in IDLE
      req(0, 2'd2, 32'h5000, 0);
      @(negedge clk);
      chk_sb("fl_rdata_kept");
      chk("fl_idle_stall", 64'(d_stall), 1);
      chk("fl_idle_req",   64'(bus_if.data_req), 0);
      step();
      @(negedge clk);
      chk("rs_addr_req",  64'(bus_if.data_req), 1);
      chk("rs_addr_addr", 64'(bus_if.data_addr), 64'h5000);

      // ---- reset while in ADDR
      rst = 1;
      step();
      rst = 0; mem_en = 0;
      @(negedge clk);
      chk("rs_req",   64'(bus_if.data_req), 0);
      chk("rs_stall", 64'(d_stall), 0);
      chk("rs_rdata", 64'(mem_rdata), 0);
      step();

      // ---- half-word load at odd address 0x1001
      req(0, 2'd1, 32'h1001, 0);
`ifdef DSB_ALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mis_adel",  64'(adel), 1);
         chk("mis_ades",  64'(ades), 0);
         chk("mis_stall", 64'(d_stall), 0);
         chk("mis_req",   64'(bus_if.data_req), 0);
         step();
      end
      mem_en = 0;
`else
      exp_q.push_back(32'h0000CAFE);
      @(negedge clk);
      chk("odd_adel",  64'({adel, ades}), 0);
      chk("odd_stall", 64'(d_stall), 1);
      step();
      bus_if.data_addr_ok = 1; bus_if.data_data_ok = 1; bus_if.data_rdata = 32'h0000CAFE;
      @(negedge clk);
      chk("odd_req",  64'(bus_if.data_req), 1);
      chk("odd_addr", 64'(bus_if.data_addr), 64'h1001);
      chk("odd_size", 64'(bus_if.data_size), 1);
      step();
      bus_if.data_addr_ok = 0; bus_if.data_data_ok = 0; bus_if.data_rdata = 0;
      @(negedge clk);
      chk("odd_done_stall", 64'(d_stall), 0);
      chk_sb("odd_done_rdata");
      step();
      mem_en = 0;
`endif
      step();
      chk("sb_empty", 64'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
